// File: rtl/alu_issue_unit.sv
// -----------------------------------------------------------------------------
// alu_issue_unit
//
// Issue and writeback front end for the combinational my_ALU. It decodes MIPS
// R-type ALU instructions plus addiu/andi/ori, reads operands from an internal
// 32x32 register file, and presents them to the ALU from a registered issue
// stage. One clock later it writes the ALU result back to the register file.
//
// Handshake: instr_ready = !rst. An instruction is accepted on a rising edge
// where instr_valid && instr_ready. There is no other back-pressure, so one
// instruction per cycle is sustained. Outputs wb_valid and illegal are
// single-cycle pulses that carry no handshake.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   instr_valid/instr_ready/instr  instruction input handshake
//   alu_a, alu_b, alu_funct        registered ALU operands / function code
//   alu_result      combinational ALU result (returned by my_ALU)
//   wb_valid, wb_rd, wb_data       writeback pulse, destination and value
//   illegal, illegal_count         dropped-instruction pulse and saturating count
//   dbg_addr, dbg_data             register-file debug read (no bypass)
// -----------------------------------------------------------------------------
module alu_issue_unit #(
  parameter int          ILL_CNT_W   = 8,
  parameter logic [5:0]  RESET_FUNCT = 6'b100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [31:0]          instr,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [5:0]           alu_funct,
  input  logic [31:0]          alu_result,
  output logic                 wb_valid,
  output logic [4:0]           wb_rd,
  output logic [31:0]          wb_data,
  output logic                 illegal,
  output logic [ILL_CNT_W-1:0] illegal_count,
  input  logic [4:0]           dbg_addr,
  output logic [31:0]          dbg_data
);

  // Instruction fields
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  fn;
  logic [15:0] imm;
  logic        unused_shamt;

  assign opcode       = instr[31:26];
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign rd           = instr[15:11];
  assign fn           = instr[5:0];
  assign imm          = instr[15:0];
  assign unused_shamt = ^instr[10:6];

  // Register file and pipeline state
  logic [31:0] regs [32];
  logic        issue_valid;
  logic [4:0]  dest;

  // Decode results
  logic        dec_legal;
  logic [5:0]  dec_funct;
  logic [4:0]  dec_dest;
  logic        dec_use_imm;
  logic [31:0] dec_imm;

  logic        accept;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] b_val;

  assign instr_ready = !rst;
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    dec_legal   = 1'b0;
    dec_funct   = RESET_FUNCT;
    dec_dest    = 5'd0;
    dec_use_imm = 1'b0;
    dec_imm     = 32'd0;
    case (opcode)
      6'b000000: begin
        case (fn)
          6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b100100, 6'b100101, 6'b100110, 6'b100111,
          6'b101010, 6'b101011: begin
            dec_legal = 1'b1;
            dec_funct = fn;
            dec_dest  = rd;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      6'b001001: begin // addiu: sign-extended immediate, add without trap
        dec_legal   = 1'b1;
        dec_funct   = 6'b100001;
        dec_dest    = rt;
        dec_use_imm = 1'b1;
        dec_imm     = {{16{imm[15]}}, imm};
      end
      6'b001100: begin // andi: zero-extended immediate
        dec_legal   = 1'b1;
        dec_funct   = 6'b100100;
        dec_dest    = rt;
        dec_use_imm = 1'b1;
        dec_imm     = {16'd0, imm};
      end
      6'b001101: begin // ori: zero-extended immediate
        dec_legal   = 1'b1;
        dec_funct   = 6'b100101;
        dec_dest    = rt;
        dec_use_imm = 1'b1;
        dec_imm     = {16'd0, imm};
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Operand read with forwarding. The only in-flight result is the one in the
  // issue stage, whose value is on alu_result this cycle; anything older has
  // already been written to regs. Register 0 is hard zero and never forwarded.
  always_comb begin
    if (rs == 5'd0)
      rs_val = 32'd0;
    else if (issue_valid && (dest != 5'd0) && (dest == rs))
      rs_val = alu_result;
    else
      rs_val = regs[rs];

    if (rt == 5'd0)
      rt_val = 32'd0;
    else if (issue_valid && (dest != 5'd0) && (dest == rt))
      rt_val = alu_result;
    else
      rt_val = regs[rt];

    b_val = dec_use_imm ? dec_imm : rt_val;
  end

  // Stage 1: issue registers. alu_a/alu_b hold when nothing issues so the
  // ALU inputs only toggle on real work.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid <= 1'b0;
      alu_a       <= 32'd0;
      alu_b       <= 32'd0;
      alu_funct   <= RESET_FUNCT;
      dest        <= 5'd0;
    end else if (accept && dec_legal) begin
      issue_valid <= 1'b1;
      alu_a       <= rs_val;
      alu_b       <= b_val;
      alu_funct   <= dec_funct;
      dest        <= dec_dest;
    end else begin
      issue_valid <= 1'b0;
      alu_funct   <= RESET_FUNCT;
    end
  end

  // Stage 2: writeback. Reset discards any op still in the issue stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_rd    <= 5'd0;
      wb_data  <= 32'd0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (issue_valid) begin
      wb_valid <= 1'b1;
      wb_rd    <= dest;
      wb_data  <= alu_result;
      if (dest != 5'd0) regs[dest] <= alu_result;
    end else begin
      wb_valid <= 1'b0;
    end
  end

  // Illegal-instruction pulse and saturating counter
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal       <= 1'b0;
      illegal_count <= '0;
    end else begin
      illegal <= accept && !dec_legal;
      if (accept && !dec_legal && (illegal_count != '1))
        illegal_count <= illegal_count + ILL_CNT_W'(1);
    end
  end

  assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs[dbg_addr];

endmodule
